conware_row_framer: RTL and testbench

- Upstream AXI4-Stream conditioning stage that sits directly in front of the conware cell core.
- Accepts the raw pixel stream from the DMA/video source and regenerates TLAST on every row boundary (WIDTH beats), so the core's input row buffer always sees exactly WIDTH beats per row.
- Adds a start-of-frame TUSER flag and counts completed frames.
- Checks the source's own TLAST against the row count and records mismatches in sticky error flags.

---
 rtl/conware_row_framer.sv | 145 ++++++++++++++
 tb/tb_conware_row_framer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conware_row_framer.sv
// AXI4-Stream row framer: regenerates TLAST every WIDTH beats and TUSER on frame start, and flags source TLAST mismatches.
// Latency 1 cycle; a two-entry skid (output + skid register) gives full throughput, and S_AXIS_TREADY drops only while the skid is full.
module conware_row_framer #(
    parameter int DWIDTH = 32,
    parameter int WIDTH  = 32,
    parameter int HEIGHT = 1
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              S_AXIS_TVALID,
    output logic              S_AXIS_TREADY,
    input  logic [DWIDTH-1:0] S_AXIS_TDATA,
    input  logic              S_AXIS_TLAST,
    output logic              M_AXIS_TVALID,
    input  logic              M_AXIS_TREADY,
    output logic [DWIDTH-1:0] M_AXIS_TDATA,
    output logic              M_AXIS_TLAST,
    output logic              M_AXIS_TUSER,
    output logic [15:0]       frame_count,
    output logic              err_early_last,
    output logic              err_late_last,
    input  logic              err_clear
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [15:0]       frame_count_q, frame_count_d;
    logic              early_q, early_d, late_q, late_d;
    logic              s_rdy_q, s_rdy_d;
    logic              m_vld_q, m_vld_d, m_last_q, m_last_d, m_user_q, m_user_d;
    logic [DWIDTH-1:0] m_dat_q, m_dat_d;
    logic              sk_vld_q, sk_vld_d, sk_last_q, sk_last_d, sk_user_q, sk_user_d;
    logic [DWIDTH-1:0] sk_dat_q, sk_dat_d;

    logic accept, out_free, in_last, in_user;

    always_comb begin
        accept        = S_AXIS_TVALID & s_rdy_q;
        out_free      = ~m_vld_q | M_AXIS_TREADY;
        in_last       = (col_q == COL_LAST);
        in_user       = (col_q == '0) && (row_q == '0);

        col_d         = col_q;
        row_d         = row_q;
        frame_count_d = frame_count_q;
        m_vld_d       = m_vld_q;
        m_dat_d       = m_dat_q;
        m_last_d      = m_last_q;
        m_user_d      = m_user_q;
        sk_vld_d      = sk_vld_q;
        sk_dat_d      = sk_dat_q;
        sk_last_d     = sk_last_q;
        sk_user_d     = sk_user_q;

        // The skid always drains first; ready is low while it is occupied, so accept never competes with it.
        if (out_free) begin
            if (sk_vld_q) begin
                m_vld_d  = 1'b1;
                m_dat_d  = sk_dat_q;
                m_last_d = sk_last_q;
                m_user_d = sk_user_q;
                sk_vld_d = 1'b0;
            end else if (accept) begin
                m_vld_d  = 1'b1;
                m_dat_d  = S_AXIS_TDATA;
                m_last_d = in_last;
                m_user_d = in_user;
            end else begin
                m_vld_d  = 1'b0;
            end
        end else if (accept) begin
            sk_vld_d  = 1'b1;
            sk_dat_d  = S_AXIS_TDATA;
            sk_last_d = in_last;
            sk_user_d = in_user;
        end

        if (accept) begin
            if (in_last) begin
                col_d = '0;
                if (row_q == ROW_LAST) begin
                    row_d         = '0;
                    frame_count_d = frame_count_q + 16'd1;
                end else begin
                    row_d = row_q + RW'(1);
                end
            end else begin
                col_d = col_q + CW'(1);
            end
        end

        // Set beats clear when both happen in the same cycle.
        early_d = (accept & S_AXIS_TLAST & ~in_last) | (early_q & ~err_clear);
        late_d  = (accept & ~S_AXIS_TLAST & in_last) | (late_q & ~err_clear);
        s_rdy_d = ~sk_vld_d;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            col_q         <= '0;
            row_q         <= '0;
            frame_count_q <= '0;
            early_q       <= 1'b0;
            late_q        <= 1'b0;
            s_rdy_q       <= 1'b0;
            m_vld_q       <= 1'b0;
            m_dat_q       <= '0;
            m_last_q      <= 1'b0;
            m_user_q      <= 1'b0;
            sk_vld_q      <= 1'b0;
            sk_dat_q      <= '0;
            sk_last_q     <= 1'b0;
            sk_user_q     <= 1'b0;
        end else begin
            col_q         <= col_d;
            row_q         <= row_d;
            frame_count_q <= frame_count_d;
            early_q       <= early_d;
            late_q        <= late_d;
            s_rdy_q       <= s_rdy_d;
            m_vld_q       <= m_vld_d;
            m_dat_q       <= m_dat_d;
            m_last_q      <= m_last_d;
            m_user_q      <= m_user_d;
            sk_vld_q      <= sk_vld_d;
            sk_dat_q      <= sk_dat_d;
            sk_last_q     <= sk_last_d;
            sk_user_q     <= sk_user_d;
        end
    end

    assign S_AXIS_TREADY  = s_rdy_q;
    assign M_AXIS_TVALID  = m_vld_q;
    assign M_AXIS_TDATA   = m_dat_q;
    assign M_AXIS_TLAST   = m_last_q;
    assign M_AXIS_TUSER   = m_user_q;
    assign frame_count    = frame_count_q;
    assign err_early_last = early_q;
    assign err_late_last  = late_q;

endmodule

// File: tb/tb_conware_row_framer.sv
// Directed bench for conware_row_framer with a scoreboard of expected {data, last, user} beats.
module tb_conware_row_framer;
    localparam int DW = 32;
    localparam int W  = 4;
    localparam int H  = 2;

    logic          ACLK;
    logic          ARESETN;
    logic          S_AXIS_TVALID;
    logic          S_AXIS_TREADY;
    logic [DW-1:0] S_AXIS_TDATA;
    logic          S_AXIS_TLAST;
    logic          M_AXIS_TVALID;
    logic          M_AXIS_TREADY;
    logic [DW-1:0] M_AXIS_TDATA;
    logic          M_AXIS_TLAST;
    logic          M_AXIS_TUSER;
    logic [15:0]   frame_count;
    logic          err_early_last;
    logic          err_late_last;
    logic          err_clear;

    conware_row_framer #(.DWIDTH(DW), .WIDTH(W), .HEIGHT(H)) dut (
        .ACLK           (ACLK),
        .ARESETN        (ARESETN),
        .S_AXIS_TVALID  (S_AXIS_TVALID),
        .S_AXIS_TREADY  (S_AXIS_TREADY),
        .S_AXIS_TDATA   (S_AXIS_TDATA),
        .S_AXIS_TLAST   (S_AXIS_TLAST),
        .M_AXIS_TVALID  (M_AXIS_TVALID),
        .M_AXIS_TREADY  (M_AXIS_TREADY),
        .M_AXIS_TDATA   (M_AXIS_TDATA),
        .M_AXIS_TLAST   (M_AXIS_TLAST),
        .M_AXIS_TUSER   (M_AXIS_TUSER),
        .frame_count    (frame_count),
        .err_early_last (err_early_last),
        .err_late_last  (err_late_last),
        .err_clear      (err_clear)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int checks = 0;
    int errors = 0;
    int stall_cycles = 0;
    int tb_col = 0;
    int tb_row = 0;
    logic [15:0] tb_frames = 16'd0;
    logic [DW+1:0] sb_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic good_last();
        return (tb_col == W - 1);
    endfunction

    // Reference framing model: tags depend only on accepted-beat position.
    task automatic push(input logic [DW-1:0] d);
        logic exp_last, exp_user;
        exp_last = (tb_col == W - 1);
        exp_user = (tb_col == 0) && (tb_row == 0);
        sb_q.push_back({d, exp_last, exp_user});
        if (exp_last) begin
            tb_col = 0;
            if (tb_row == H - 1) begin
                tb_row = 0;
                tb_frames = tb_frames + 16'd1;
            end else begin
                tb_row++;
            end
        end else begin
            tb_col++;
        end
    endtask

    task automatic send(input logic [DW-1:0] d, input logic src_last);
        int waitc = 0;
        S_AXIS_TVALID = 1'b1;
        S_AXIS_TDATA  = d;
        S_AXIS_TLAST  = src_last;
        while (!S_AXIS_TREADY && waitc < 200) begin
            @(posedge ACLK); #1;
            waitc++;
        end
        stall_cycles += waitc;
        if (!S_AXIS_TREADY) begin
            checks++;
            errors++;
            $error("FAIL send_timeout data=%0h observed_tready=0 expected_tready=1", d);
        end else begin
            push(d);
            @(posedge ACLK); #1;
        end
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TLAST  = 1'b0;
    endtask

    task automatic drain();
        int c = 0;
        while (sb_q.size() != 0 && c < 300) begin
            @(posedge ACLK); #1;
            c++;
        end
        check("drain_empty", 64'(sb_q.size()), 64'd0);
    endtask

    always @(negedge ACLK) begin
        if (ARESETN && M_AXIS_TVALID && M_AXIS_TREADY) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_beat observed_data=%0h expected=none", M_AXIS_TDATA);
            end else begin
                check("beat_data_last_user", 64'({M_AXIS_TDATA, M_AXIS_TLAST, M_AXIS_TUSER}),
                      64'(sb_q.pop_front()));
            end
        end
    end

    initial begin
        int acc;
        logic hs;
        ARESETN       = 1'b0;
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TDATA  = '0;
        S_AXIS_TLAST  = 1'b0;
        M_AXIS_TREADY = 1'b0;
        err_clear     = 1'b0;
        repeat (3) @(posedge ACLK);
        #1;
        check("rst_tvalid", 64'(M_AXIS_TVALID), 64'd0);
        check("rst_tlast", 64'(M_AXIS_TLAST), 64'd0);
        check("rst_tuser", 64'(M_AXIS_TUSER), 64'd0);
        check("rst_tdata", 64'(M_AXIS_TDATA), 64'd0);
        check("rst_tready", 64'(S_AXIS_TREADY), 64'd0);
        check("rst_frames", 64'(frame_count), 64'd0);
        check("rst_errs", 64'({err_early_last, err_late_last}), 64'd0);
        ARESETN = 1'b1;
        #1;
        check("tready_before_edge", 64'(S_AXIS_TREADY), 64'd0);
        @(posedge ACLK); #1;
        check("tready_after_edge", 64'(S_AXIS_TREADY), 64'd1);

        // Full-rate streaming of two frames.
        M_AXIS_TREADY = 1'b1;
        check("tvalid_idle", 64'(M_AXIS_TVALID), 64'd0);
        send(0, good_last());
        check("latency_1cyc", 64'(M_AXIS_TVALID), 64'd1);
        for (int i = 1; i < 16; i++) begin
            send(DW'(i), good_last());
            if (i == 7) check("frames_after_8", 64'(frame_count), 64'd1);
        end
        check("frames_after_16", 64'(frame_count), 64'd2);
        check("no_stall_stream", 64'(stall_cycles), 64'd0);
        check("errs_clean", 64'({err_early_last, err_late_last}), 64'd0);
        drain();

        // Backpressure mid-row: output holds, skid absorbs exactly one more beat.
        send(16, good_last());
        send(17, good_last());
        M_AXIS_TREADY = 1'b0;
        S_AXIS_TVALID = 1'b1;
        S_AXIS_TDATA  = 18;
        S_AXIS_TLAST  = good_last();
        acc = 0;
        for (int k = 0; k < 5; k++) begin
            hs = S_AXIS_TREADY;
            @(posedge ACLK); #1;
            if (hs) begin
                push(S_AXIS_TDATA);
                acc++;
                S_AXIS_TDATA = S_AXIS_TDATA + 1;
                S_AXIS_TLAST = good_last();
            end
            check("stall_hold_data", 64'({M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TLAST, M_AXIS_TUSER}),
                  64'({1'b1, 32'd17, 1'b0, 1'b0}));
        end
        check("stall_accepted", 64'(acc), 64'd1);
        check("stall_tready_low", 64'(S_AXIS_TREADY), 64'd0);
        M_AXIS_TREADY = 1'b1;
        for (int i = 19; i < 24; i++) send(DW'(i), good_last());
        drain();
        check("frames_after_bp", 64'(frame_count), 64'd3);

        // Early source TLAST on beat 1.
        send(32, 1'b0);
        check("early_not_yet", 64'(err_early_last), 64'd0);
        send(33, 1'b1);
        check("early_set", 64'(err_early_last), 64'd1);
        send(34, 1'b0);
        send(35, 1'b1);
        check("early_frames", 64'(frame_count), 64'd3);
        check("early_no_late", 64'(err_late_last), 64'd0);

        // Missing source TLAST on beat 3.
        for (int i = 36; i < 40; i++) send(DW'(i), 1'b0);
        check("late_set", 64'(err_late_last), 64'd1);
        check("early_sticky", 64'(err_early_last), 64'd1);
        check("frames_after_late", 64'(frame_count), 64'(tb_frames));

        err_clear = 1'b1;
        @(posedge ACLK); #1;
        err_clear = 1'b0;
        check("clear_both", 64'({err_early_last, err_late_last}), 64'd0);

        err_clear = 1'b1;
        send(48, 1'b1);
        err_clear = 1'b0;
        check("clear_vs_set", 64'({err_early_last, err_late_last}), 64'b10);
        for (int i = 49; i < 56; i++) send(DW'(i), good_last());
        drain();
        check("frames_before_reset", 64'(frame_count), 64'd5);

        // Reset with the output stalled and the skid loaded.
        for (int i = 60; i < 66; i++) send(DW'(i), good_last());
        M_AXIS_TREADY = 1'b0;
        send(66, good_last());
        ARESETN = 1'b0;
        #1;
        check("async_rst_tvalid", 64'(M_AXIS_TVALID), 64'd0);
        check("async_rst_tdata", 64'(M_AXIS_TDATA), 64'd0);
        check("async_rst_frames", 64'(frame_count), 64'd0);
        check("async_rst_tready", 64'(S_AXIS_TREADY), 64'd0);
        check("async_rst_errs", 64'({err_early_last, err_late_last}), 64'd0);
        sb_q.delete();
        tb_col = 0;
        tb_row = 0;
        tb_frames = 16'd0;
        @(posedge ACLK); #1;
        ARESETN = 1'b1;
        @(posedge ACLK); #1;
        M_AXIS_TREADY = 1'b1;
        for (int i = 100; i < 108; i++) send(DW'(i), good_last());
        drain();
        check("frames_after_reset", 64'(frame_count), 64'd1);

        // Frame counter wrap.
        force dut.frame_count_q = 16'hFFFF;
        #1;
        release dut.frame_count_q;
        tb_frames = 16'hFFFF;
        for (int i = 200; i < 204; i++) send(DW'(i), good_last());
        check("wrap_hold", 64'(frame_count), 64'hFFFF);
        for (int i = 204; i < 208; i++) send(DW'(i), good_last());
        check("wrap_zero", 64'(frame_count), 64'h0000);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
